// File: rtl/pe_reducer.sv
// pe_reducer: three multiply lanes whose products are merged by target entry
// and accumulated into a ten-entry output buffer. Three-stage pipeline:
// operand capture, multiply, merge-and-commit.
// Optional build macro: PE_REDUCER_SAT_EN makes the per-entry accumulate
// saturate at all ones. Without it, the accumulate wraps modulo 2^ACCW.

// One multiply lane. It captures the operands and the selected coordinate,
// then registers the full-width product together with its buffer index.
module pe_reducer_lane #(
    parameter int DW       = 16,
    parameter int AW       = 7,
    parameter int ADDR_SEL = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            start,
    input  logic            s0_vld,
    input  logic [3*AW-1:0] addr,
    input  logic [DW-1:0]   w,
    input  logic [DW-1:0]   ia,
    output logic [AW-1:0]   idx,
    output logic [2*DW-1:0] prod
);
    logic [AW-1:0] idx_s0;
    logic [DW-1:0] w_s0;
    logic [DW-1:0] ia_s0;

    // Stage 0: capture operands and pick the coordinate field that indexes the buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_s0 <= '0;
            w_s0   <= '0;
            ia_s0  <= '0;
        end else if (start) begin
            idx_s0 <= addr[ADDR_SEL*AW +: AW];
            w_s0   <= w;
            ia_s0  <= ia;
        end
    end

    // Stage 1: form the unsigned product and carry the index alongside it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx  <= '0;
            prod <= '0;
        end else if (s0_vld) begin
            idx  <= idx_s0;
            prod <= {{DW{1'b0}}, w_s0} * {{DW{1'b0}}, ia_s0};
        end
    end
endmodule

module pe_reducer #(
    parameter int NLANE    = 3,
    parameter int NBUF     = 10,
    parameter int DW       = 16,
    parameter int AW       = 7,
    parameter int ACCW     = 36,
    parameter int ADDR_SEL = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic [NLANE-1:0][3*AW-1:0]     i_addr,
    input  logic [NLANE-1:0][DW-1:0]       i_w,
    input  logic [NLANE-1:0][DW-1:0]       i_ia,
    output logic [NBUF-1:0][ACCW-1:0]      o_buf,
    output logic                           o_finish
);
    localparam int STAGES = 2;

    // vld_pipe[0]: operands held. vld_pipe[1]: products held. vld_pipe[2]: commit done.
    logic [STAGES:0]                 vld_pipe;
    logic [NLANE-1:0][AW-1:0]        lane_idx;
    logic [NLANE-1:0][2*DW-1:0]      lane_prod;
    logic [NBUF-1:0][ACCW-1:0]       batch_sum;
    logic [NBUF-1:0][ACCW-1:0]       buf_nxt;

    genvar g;
    generate
        for (g = 0; g < NLANE; g++) begin : g_lane
            pe_reducer_lane #(
                .DW       (DW),
                .AW       (AW),
                .ADDR_SEL (ADDR_SEL)
            ) u_lane (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .start   (i_start),
                .s0_vld  (vld_pipe[0]),
                .addr    (i_addr[g]),
                .w       (i_w[g]),
                .ia      (i_ia[g]),
                .idx     (lane_idx[g]),
                .prod    (lane_prod[g])
            );
        end
    endgenerate

    // Merge lanes per entry. An index at or beyond NBUF matches no entry, so
    // that lane simply drops out of every sum.
    always_comb begin
        batch_sum = '0;
        for (int j = 0; j < NBUF; j++) begin
            for (int k = 0; k < NLANE; k++) begin
                if (lane_idx[k] == AW'(j))
                    batch_sum[j] = batch_sum[j] + ACCW'(lane_prod[k]);
            end
        end
    end

    // Next value of each entry after adding its merged batch sum.
    always_comb begin
        buf_nxt = '0;
        for (int j = 0; j < NBUF; j++) begin
`ifdef PE_REDUCER_SAT_EN
            logic [ACCW:0] wide;
            wide = {1'b0, o_buf[j]} + {1'b0, batch_sum[j]};
            buf_nxt[j] = wide[ACCW] ? {ACCW{1'b1}} : wide[ACCW-1:0];
`else
            buf_nxt[j] = o_buf[j] + batch_sum[j];
`endif
        end
    end

    // Valid shift register. Reset drops every in-flight batch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vld_pipe <= '0;
        else          vld_pipe <= {vld_pipe[STAGES-1:0], i_start};
    end

    // Stage 2: commit the merged sums. Only this stage writes the buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         o_buf <= '0;
        else if (vld_pipe[1]) o_buf <= buf_nxt;
    end

    assign o_finish = vld_pipe[STAGES];
endmodule

// File: tb/tb_pe_reducer.sv
// Bench for pe_reducer: directed steps plus random batches, checked against
// a per-entry arithmetic model of the buffer.
module tb_pe_reducer;
    localparam int NLANE = 3;
    localparam int NBUF  = 10;
    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int ACCW  = 36;
    localparam int SEL   = 0;
    localparam longint unsigned MAXV = (64'd1 << ACCW) - 1;

    logic                       i_clk;
    logic                       i_rst_n;
    logic                       i_start;
    logic [NLANE-1:0][3*AW-1:0] i_addr;
    logic [NLANE-1:0][DW-1:0]   i_w;
    logic [NLANE-1:0][DW-1:0]   i_ia;
    logic [NBUF-1:0][ACCW-1:0]  o_buf;
    logic                       o_finish;

    pe_reducer #(
        .NLANE(NLANE), .NBUF(NBUF), .DW(DW), .AW(AW), .ACCW(ACCW), .ADDR_SEL(SEL)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_addr(i_addr), .i_w(i_w), .i_ia(i_ia),
        .o_buf(o_buf), .o_finish(o_finish)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int fin_cnt = 0;
    int fin_exp = 0;

    longint unsigned model [NBUF];
    int p_idx [NLANE];
    int p_w   [NLANE];
    int p_ia  [NLANE];

    // Count finish pulses, sampled away from the rising edge.
    always @(negedge i_clk) if (o_finish === 1'b1) fin_cnt++;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int j = 0; j < NBUF; j++)
            chk($sformatf("%s buf[%0d]", tag, j), 64'(o_buf[j]), model[j]);
    endtask

    task automatic set_lane(input int k, input int idx, input int w, input int ia);
        logic [AW-1:0] f [3];
        for (int i = 0; i < 3; i++) f[i] = AW'($urandom_range(0, (1 << AW) - 1));
        f[SEL] = AW'(idx);
        i_addr[k] = {f[2], f[1], f[0]};
        i_w[k]    = DW'(w);
        i_ia[k]   = DW'(ia);
        p_idx[k] = idx; p_w[k] = w; p_ia[k] = ia;
    endtask

    task automatic set3(input int a0, input int a1, input int a2, input int w0, input int w1,
                        input int w2, input int x0, input int x1, input int x2);
        set_lane(0, a0, w0, x0);
        set_lane(1, a1, w1, x1);
        set_lane(2, a2, w2, x2);
    endtask

    // Expected effect of one committed batch on the buffer.
    task automatic model_apply();
        longint unsigned s [NBUF];
        longint unsigned t;
        for (int j = 0; j < NBUF; j++) s[j] = 0;
        for (int k = 0; k < NLANE; k++)
            if (p_idx[k] < NBUF)
                s[p_idx[k]] += longint'(p_w[k]) * longint'(p_ia[k]);
        for (int j = 0; j < NBUF; j++) begin
            t = model[j] + s[j];
`ifdef PE_REDUCER_SAT_EN
            model[j] = (t > MAXV) ? MAXV : t;
`else
            model[j] = t & MAXV;
`endif
        end
        fin_exp++;
    endtask

    // Issue one batch from the current negedge and follow its finish pulse.
    task automatic single_batch(input string tag);
        i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        chk({tag, " finish early0"}, 64'(o_finish), 0);
        @(negedge i_clk);
        chk({tag, " finish early1"}, 64'(o_finish), 0);
        @(negedge i_clk);
        model_apply();
        chk({tag, " finish pulse"}, 64'(o_finish), 1);
        check_all(tag);
        @(negedge i_clk);
        chk({tag, " finish end"}, 64'(o_finish), 0);
    endtask

    initial begin
        for (int j = 0; j < NBUF; j++) model[j] = 0;
        i_rst_n = 1'b0; i_start = 1'b0; i_addr = '0; i_w = '0; i_ia = '0;

        // Reset, observed before any clock edge.
        #3;
        chk("reset finish", 64'(o_finish), 0);
        check_all("reset");
        @(negedge i_clk); i_rst_n = 1'b1;

        // Distinct lanes.
        @(negedge i_clk);
        set3(0, 1, 2, 15, 16, 17, 3, 2, 1);
        single_batch("distinct");
        chk("distinct buf0 const", 64'(o_buf[0]), 45);
        chk("distinct buf1 const", 64'(o_buf[1]), 32);
        chk("distinct buf2 const", 64'(o_buf[2]), 17);

        // Merge into entry 2 plus accumulate.
        set3(2, 2, 3, 4, 5, 6, 3, 2, 1);
        single_batch("merge");
        chk("merge buf2 const", 64'(o_buf[2]), 39);
        chk("merge buf3 const", 64'(o_buf[3]), 6);

        // Out-of-range lane 0.
        set3(12, 5, 5, 7777, 1, 1, 9999, 1, 1);
        single_batch("oor");
        chk("oor buf5 const", 64'(o_buf[5]), 2);

        // Back-to-back starts on three consecutive cycles.
        for (int b = 0; b < 3; b++) begin
            set3(4, 4, 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            i_start = 1'b1;
            model_apply();
            @(negedge i_clk);
        end
        i_start = 1'b0;
        chk("b2b finish0", 64'(o_finish), 1);
        @(negedge i_clk); chk("b2b finish1", 64'(o_finish), 1);
        @(negedge i_clk); chk("b2b finish2", 64'(o_finish), 1);
        @(negedge i_clk); chk("b2b finish3", 64'(o_finish), 0);
        check_all("b2b");
        chk("b2b buf4 const", 64'(o_buf[4]), 64'd9 * 64'hFFFE0001);

        // Overflow of entry 9: 18 maximal products.
        for (int b = 0; b < 6; b++) begin
            set3(9, 9, 9, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            i_start = 1'b1;
            model_apply();
            @(negedge i_clk);
        end
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        check_all("ovf");
`ifdef PE_REDUCER_SAT_EN
        chk("ovf buf9 const", 64'(o_buf[9]), 64'hF_FFFF_FFFF);
`else
        chk("ovf buf9 const", 64'(o_buf[9]), 64'h1_FFDC_0012);
`endif
        chk("finish count", 64'(fin_cnt), 64'(fin_exp));

        // Reset while a batch sits in stage 0.
        set3(0, 1, 2, 100, 200, 300, 5, 5, 5);
        i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        for (int j = 0; j < NBUF; j++) model[j] = 0;
        chk("midrst finish", 64'(o_finish), 0);
        check_all("midrst async");
        @(negedge i_clk); @(negedge i_clk); i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        check_all("midrst after");
        chk("midrst finish count", 64'(fin_cnt), 64'(fin_exp));

        // Random batches with random gaps and some out-of-range indices.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < NLANE; k++)
                    set_lane(k, $urandom_range(0, 13), $urandom_range(0, 65535),
                             $urandom_range(0, 65535));
                i_start = 1'b1;
                model_apply();
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        check_all("rand");
        chk("rand finish count", 64'(fin_cnt), 64'(fin_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
